id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register feeding the ALU: captures decoded operands and control from ID,
//  selects the ALU B operand, decodes funct/ALUOp into the 3-bit ALUCtrl code the ALU consumes,
//  and reports load-use hazards back to ID. Supports stall (hold) and flush (bubble insertion).
// PARAMETERS
//  XLEN     32  datapath width
//  RADDR_W   5  register address width
// PORTS
//  clk_i        in   1     clock, all state updates on posedge
//  rst_i        in   1     synchronous, active-high reset
//  stall_i      in   1     hold current contents
//  flush_i      in   1     load a bubble
//  valid_i      in   1     ID holds a real instruction
//  rs1_data_i   in   XLEN  register-file read data 1
//  rs2_data_i   in   XLEN  register-file read data 2
//  imm_i        in   XLEN  sign-extended immediate
//  rs1_addr_i   in   5     ID source register 1
//  rs2_addr_i   in   5     ID source register 2
//  rd_addr_i    in   5     destination register
//  alu_op_i     in   2     00 mem-address, 01 branch, 10 R-type, 11 I-type
//  alu_src_i    in   1     1: B = immediate
//  funct_i      in   10    {funct7, funct3}
//  reg_write_i / mem_read_i / mem_write_i / mem_to_reg_i  in  1 each  control bits
//  data1_o      out  XLEN  ALU operand A
//  data2_o      out  XLEN  ALU operand B
//  ALUCtrl_o    out  3     ALU operation code
//  rs2_data_o   out  XLEN  store data
//  rd_addr_o / rs1_addr_o / rs2_addr_o  out  5  registered addresses
//  valid_o, illegal_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each
//  load_use_o   out  1     combinational: stall request to the hazard logic
//  [ID_EX_FWD_EN only] ex_mem_rd_i 5, ex_mem_wr_i 1, ex_mem_data_i XLEN,
//                      mem_wb_rd_i 5, mem_wb_wr_i 1, mem_wb_data_i XLEN  (all in)
// BEHAVIOUR
//  - Update priority on posedge: rst_i > flush_i > stall_i > load. Latency is one cycle, ID to EX.
//  - Reset and bubble: every registered output is 0. valid_o=0, all control bits 0, ALUCtrl_o=AND (000).
//  - Flush takes effect while stalled. Flush wins over stall and a bubble is loaded.
//  - Stall: all registers hold. load_use_o is re-evaluated against the new ID addresses.
//  - valid_i=0 on load: the stage loads a bubble.
//  - Operand B on load: alu_src_i ? imm_i : rs2_data_i. For SRAI, B = {27'b0, imm_i[4:0]}.
//  - Decode (registered):
//      alu_op 00 -> ADD(011); alu_op 01 -> SUB(100)
//      alu_op 10, {f7,f3}: 0000000_111 AND(000), 0000000_100 XOR(001), 0000000_001 SLL(010),
//                          0000000_000 ADD(011), 0100000_000 SUB(100), 0000001_000 MUL(101)
//      alu_op 11: f3=000 ADDI(110); f3=101 with f7=0100000 SRAI(111)
//      Any other code -> ADD, illegal_o=1, reg_write_o=0, mem_write_o=0. illegal_o=0 otherwise.
//  - load_use_o = valid_o & mem_read_o & rd_addr_o!=0 & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i).
//  - x0 is never a hazard or forwarding source.
// CONFIGURATION
//  ID_EX_FWD_EN defined:
//  - data1_o selects EX/MEM, else MEM/WB, else the registered value. A source qualifies when
//    its wr_i=1, rd!=0 and rd==rs1_addr_o.
//  - data2_o is forwarded the same way only when the registered alu_src=0.
//  - rs2_data_o uses the same rs2 forwarding, which also covers stores.
//  - EX/MEM has priority over MEM/WB.
//  ID_EX_FWD_EN undefined:
//  - The forwarding ports are absent and data*_o come straight from registers.
// STRUCTURE
//  - Package cpu_pkg holds the ALUCtrl localparams (ALU_AND..ALU_SRAI), the ALUOp codes,
//    and the funct7 constants F7_BASE, F7_ALT and F7_MULDIV.
//  - Sub-module alu_ctrl_decode is combinational: {alu_op, funct} -> {ALUCtrl, illegal}.
//    It is instantiated once and its outputs are registered here.
// TESTING
//  1. rst_i=1 for 2 cycles with random inputs -> all outputs 0, ALUCtrl_o=000, load_use_o=0.
//  2. R-type f7=0100000 f3=000, rs1=9, rs2=4 -> next cycle ALUCtrl_o=100, data1_o=9, data2_o=4, valid_o=1.
//  3. I-type f3=101 f7=0100000, imm=0x405 -> ALUCtrl_o=111, data2_o=5. Unknown f3=011 -> illegal_o=1, reg_write_o=0.
//  4. Load into rd=x5, next ID rs1=x5 -> load_use_o=1. Same with rd=x0 -> load_use_o=0.
//  5. stall_i=1 for 3 cycles -> outputs frozen. flush_i=1 with stall_i=1 -> bubble next cycle.
//  6. [FWD] rs1_addr_o=3, ex_mem_rd=3 (data 0xAA) and mem_wb_rd=3 (data 0xBB), both wr=1
//     -> data1_o=0xAA. With ex_mem_wr=0 -> 0xBB.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the integer pipeline:
//   - ALU_*   : 3-bit ALUCtrl codes consumed by the ALU
//   - ALUOP_* : 2-bit ALUOp class produced by the main decoder
//   - F7_*    : funct7 values that select the alternate and mul/div operations
//   - F3_*    : funct3 values recognised by the ALU control decoder
// No ports; imported with import cpu_pkg::*.
// -----------------------------------------------------------------------------
package cpu_pkg;

    // ALU operation codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    // ALUOp classes from the main decoder
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // funct7 values
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // funct3 values
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational ALU control decoder: {alu_op, funct7, funct3} -> ALUCtrl.
// Unrecognised encodings fall back to ADD and raise illegal.
// Ports:
//   alu_op   in  2   ALUOp class (mem / branch / R-type / I-type)
//   funct    in  10  {funct7, funct3}
//   alu_ctrl out 3   ALU operation code
//   illegal  out 1   encoding not supported
// -----------------------------------------------------------------------------
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [9:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);

    logic [6:0] f7;
    logic [2:0] f3;

    assign f7 = funct[9:3];
    assign f3 = funct[2:0];

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (alu_op)
            ALUOP_MEM:    alu_ctrl = ALU_ADD;
            ALUOP_BRANCH: alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    {F7_BASE,   F3_AND}: alu_ctrl = ALU_AND;
                    {F7_BASE,   F3_XOR}: alu_ctrl = ALU_XOR;
                    {F7_BASE,   F3_SLL}: alu_ctrl = ALU_SLL;
                    {F7_BASE,   F3_ADD}: alu_ctrl = ALU_ADD;
                    {F7_ALT,    F3_ADD}: alu_ctrl = ALU_SUB;
                    {F7_MULDIV, F3_ADD}: alu_ctrl = ALU_MUL;
                    default:             illegal  = 1'b1;
                endcase
            end
            default: begin
                // I-type: funct7 is immediate bits for ADDI, so only SRAI checks it
                if (f3 == F3_ADD) begin
                    alu_ctrl = ALU_ADDI;
                end else if ((f3 == F3_SR) && (f7 == F7_ALT)) begin
                    alu_ctrl = ALU_SRAI;
                end else begin
                    illegal = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register. Captures decoded operands and control from ID,
// selects ALU operand B, registers the ALUCtrl code and reports load-use hazards
// combinationally back to ID.
// Update priority on posedge clk_i: rst_i > flush_i > stall_i > load.
// A bubble (reset, flush, or valid_i=0 on load) clears every registered field,
// which also leaves ALUCtrl_o = AND.
//
// Optional feature macro: ID_EX_FWD_EN
//   defined   : EX/MEM and MEM/WB forwarding ports exist; data1_o, data2_o (when
//               B is not an immediate) and rs2_data_o are forwarded, EX/MEM first.
//   undefined : forwarding ports are absent, outputs come straight from registers.
//
// Ports:
//   clk_i, rst_i, stall_i, flush_i, valid_i            control
//   rs1_data_i, rs2_data_i, imm_i                      operands from ID
//   rs1_addr_i, rs2_addr_i, rd_addr_i                  register addresses from ID
//   alu_op_i, alu_src_i, funct_i                       ALU decode inputs
//   reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i control bits
//   ex_mem_*, mem_wb_*                                 forwarding sources (macro only)
//   data1_o, data2_o, ALUCtrl_o, rs2_data_o            EX datapath
//   rd_addr_o, rs1_addr_o, rs2_addr_o                  registered addresses
//   valid_o, illegal_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o
//   load_use_o                                         combinational stall request
// -----------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic [1:0]         alu_op_i,
    input  logic               alu_src_i,
    input  logic [9:0]         funct_i,
    input  logic               reg_write_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic               mem_to_reg_i,
`ifdef ID_EX_FWD_EN
    input  logic [RADDR_W-1:0] ex_mem_rd_i,
    input  logic               ex_mem_wr_i,
    input  logic [XLEN-1:0]    ex_mem_data_i,
    input  logic [RADDR_W-1:0] mem_wb_rd_i,
    input  logic               mem_wb_wr_i,
    input  logic [XLEN-1:0]    mem_wb_data_i,
`endif
    output logic [XLEN-1:0]    data1_o,
    output logic [XLEN-1:0]    data2_o,
    output logic [2:0]         ALUCtrl_o,
    output logic [XLEN-1:0]    rs2_data_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic [RADDR_W-1:0] rs1_addr_o,
    output logic [RADDR_W-1:0] rs2_addr_o,
    output logic               valid_o,
    output logic               illegal_o,
    output logic               reg_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_to_reg_o,
    output logic               load_use_o
);

    typedef struct packed {
        logic               valid;
        logic               illegal;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
`ifdef ID_EX_FWD_EN
        logic               b_is_imm;   // B came from the immediate, never forwarded
`endif
        logic [2:0]         alu_ctrl;
        logic [XLEN-1:0]    data1;
        logic [XLEN-1:0]    data2;
        logic [XLEN-1:0]    rs2_data;
        logic [RADDR_W-1:0] rd_addr;
        logic [RADDR_W-1:0] rs1_addr;
        logic [RADDR_W-1:0] rs2_addr;
    } stage_t;

    stage_t     stage_reg;
    stage_t     stage_next;
    stage_t     load_val;
    logic [2:0] dec_ctrl;
    logic       dec_illegal;
    logic       is_srai;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op   (alu_op_i),
        .funct    (funct_i),
        .alu_ctrl (dec_ctrl),
        .illegal  (dec_illegal)
    );

    assign is_srai = (dec_ctrl == ALU_SRAI);

    // Value captured on a normal load; a non-valid ID slot becomes a bubble
    always_comb begin
        load_val = '0;
        if (valid_i) begin
            load_val.valid      = 1'b1;
            load_val.illegal    = dec_illegal;
            load_val.alu_ctrl   = dec_ctrl;
            // an illegal instruction must not change architectural state
            load_val.reg_write  = reg_write_i & ~dec_illegal;
            load_val.mem_write  = mem_write_i & ~dec_illegal;
            load_val.mem_read   = mem_read_i;
            load_val.mem_to_reg = mem_to_reg_i;
`ifdef ID_EX_FWD_EN
            load_val.b_is_imm   = alu_src_i | is_srai;
`endif
            load_val.data1      = rs1_data_i;
            // SRAI only consumes the 5-bit shift amount; upper immediate bits carry funct7
            if (is_srai) begin
                load_val.data2 = {{(XLEN-5){1'b0}}, imm_i[4:0]};
            end else if (alu_src_i) begin
                load_val.data2 = imm_i;
            end else begin
                load_val.data2 = rs2_data_i;
            end
            load_val.rs2_data   = rs2_data_i;
            load_val.rd_addr    = rd_addr_i;
            load_val.rs1_addr   = rs1_addr_i;
            load_val.rs2_addr   = rs2_addr_i;
        end
    end

    always_comb begin
        stage_next = load_val;
        if (flush_i) begin
            stage_next = '0;
        end else if (stall_i) begin
            stage_next = stage_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign ALUCtrl_o    = stage_reg.alu_ctrl;
    assign rd_addr_o    = stage_reg.rd_addr;
    assign rs1_addr_o   = stage_reg.rs1_addr;
    assign rs2_addr_o   = stage_reg.rs2_addr;
    assign valid_o      = stage_reg.valid;
    assign illegal_o    = stage_reg.illegal;
    assign reg_write_o  = stage_reg.reg_write;
    assign mem_read_o   = stage_reg.mem_read;
    assign mem_write_o  = stage_reg.mem_write;
    assign mem_to_reg_o = stage_reg.mem_to_reg;

    // Load in EX whose destination is read by the instruction now in ID
    assign load_use_o = stage_reg.valid & stage_reg.mem_read
                      & (stage_reg.rd_addr != '0)
                      & ((stage_reg.rd_addr == rs1_addr_i) | (stage_reg.rd_addr == rs2_addr_i));

`ifdef ID_EX_FWD_EN
    // index 0: rs1 operand, index 1: rs2 operand
    logic [RADDR_W-1:0] src_addr [2];
    logic [XLEN-1:0]    src_val  [2];
    logic [XLEN-1:0]    fwd_val  [2];

    assign src_addr[0] = stage_reg.rs1_addr;
    assign src_addr[1] = stage_reg.rs2_addr;
    assign src_val[0]  = stage_reg.data1;
    assign src_val[1]  = stage_reg.rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic ex_hit;
            logic wb_hit;
            // x0 is hard-wired zero, so it can never be a forwarding source
            assign ex_hit = ex_mem_wr_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == src_addr[gi]);
            assign wb_hit = mem_wb_wr_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == src_addr[gi]);
            assign fwd_val[gi] = ex_hit ? ex_mem_data_i :
                                 wb_hit ? mem_wb_data_i : src_val[gi];
        end
    endgenerate

    assign data1_o    = fwd_val[0];
    assign data2_o    = stage_reg.b_is_imm ? stage_reg.data2 : fwd_val[1];
    assign rs2_data_o = fwd_val[1];
`else
    assign data1_o    = stage_reg.data1;
    assign data2_o    = stage_reg.data2;
    assign rs2_data_o = stage_reg.rs2_data;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// Directed-vector bench for id_ex_stage. A driver applies one vector per cycle
// and queues the hand-computed outputs expected at the following negedge; an
// independent monitor pops and compares at every negedge.
module tb_id_ex_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, valid;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [9:0]  funct;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
`ifdef ID_EX_FWD_EN
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic        ex_mem_wr, mem_wb_wr;
    logic [31:0] ex_mem_data, mem_wb_data;
`endif
    logic [31:0] data1_o, data2_o, rs2_data_o;
    logic [2:0]  alu_ctrl_o;
    logic [4:0]  rd_addr_o, rs1_addr_o, rs2_addr_o;
    logic        valid_o, illegal_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
    logic        load_use_o;

    id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .valid_i      (valid),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .imm_i        (imm),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rd_addr_i    (rd_addr),
        .alu_op_i     (alu_op),
        .alu_src_i    (alu_src),
        .funct_i      (funct),
        .reg_write_i  (reg_write),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .mem_to_reg_i (mem_to_reg),
`ifdef ID_EX_FWD_EN
        .ex_mem_rd_i  (ex_mem_rd),
        .ex_mem_wr_i  (ex_mem_wr),
        .ex_mem_data_i(ex_mem_data),
        .mem_wb_rd_i  (mem_wb_rd),
        .mem_wb_wr_i  (mem_wb_wr),
        .mem_wb_data_i(mem_wb_data),
`endif
        .data1_o      (data1_o),
        .data2_o      (data2_o),
        .ALUCtrl_o    (alu_ctrl_o),
        .rs2_data_o   (rs2_data_o),
        .rd_addr_o    (rd_addr_o),
        .rs1_addr_o   (rs1_addr_o),
        .rs2_addr_o   (rs2_addr_o),
        .valid_o      (valid_o),
        .illegal_o    (illegal_o),
        .reg_write_o  (reg_write_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .load_use_o   (load_use_o)
    );

    typedef struct packed {
        logic        rst, stall, flush, valid;
        logic [31:0] rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic [1:0]  op;
        logic        src;
        logic [9:0]  funct;
        logic [3:0]  ctl;       // {reg_write, mem_read, mem_write, mem_to_reg}
        logic [4:0]  ex_rd, wb_rd;
        logic        ex_wr, wb_wr;
        logic [31:0] ex_data, wb_data;
    } vec_t;

    typedef struct packed {
        logic        valid, illegal;
        logic [2:0]  ctrl;
        logic [31:0] d1, d2, rs2d;
        logic [4:0]  rs1a, rs2a, rd;
        logic [3:0]  ctl;
        logic        lu;
    } exp_t;

    exp_t sb[$];
    exp_t pending;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;

    function automatic vec_t vi(input logic v, input logic [1:0] op, input logic src,
                                input logic [9:0] fn, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] im, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [4:0] rd, input logic [3:0] ctl);
        vec_t r;
        r = '0;
        r.valid = v; r.op = op; r.src = src; r.funct = fn;
        r.rs1d = d1; r.rs2d = d2; r.imm = im;
        r.rs1a = a1; r.rs2a = a2; r.rd = rd; r.ctl = ctl;
        return r;
    endfunction

    function automatic exp_t ex(input logic v, input logic ill, input logic [2:0] ctrl,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] s2,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                                input logic [3:0] ctl);
        exp_t r;
        r = '0;
        r.valid = v; r.illegal = ill; r.ctrl = ctrl;
        r.d1 = d1; r.d2 = d2; r.rs2d = s2;
        r.rs1a = a1; r.rs2a = a2; r.rd = rd; r.ctl = ctl;
        return r;
    endfunction

    function automatic vec_t vrand_rst();
        vec_t r;
        r = vi(1'($urandom()), 2'($urandom()), 1'($urandom()), 10'($urandom()),
               $urandom(), $urandom(), $urandom(), 5'($urandom()), 5'($urandom()),
               5'($urandom()), 4'($urandom()));
        r.rst   = 1'b1;
        r.stall = 1'($urandom());
        r.flush = 1'($urandom());
        return r;
    endfunction

    // Apply one vector for one cycle. The record queued now is checked at the
    // next negedge: registers from the previous vector, load_use against this one.
    task automatic step(input vec_t v, input exp_t e, input logic lu);
        exp_t r;
        rst = v.rst; stall = v.stall; flush = v.flush; valid = v.valid;
        rs1_data = v.rs1d; rs2_data = v.rs2d; imm = v.imm;
        rs1_addr = v.rs1a; rs2_addr = v.rs2a; rd_addr = v.rd;
        alu_op = v.op; alu_src = v.src; funct = v.funct;
        {reg_write, mem_read, mem_write, mem_to_reg} = v.ctl;
`ifdef ID_EX_FWD_EN
        ex_mem_rd = v.ex_rd; ex_mem_wr = v.ex_wr; ex_mem_data = v.ex_data;
        mem_wb_rd = v.wb_rd; mem_wb_wr = v.wb_wr; mem_wb_data = v.wb_data;
`endif
        r = pending;
        r.lu = lu;
        sb.push_back(r);
        pending = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_assert++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL txn %0d %s: got %h expected %h", n_txn, nm, act, expv);
        end
    endtask

    // Monitor: compares every presented cycle against the queued expectation
    initial begin
        exp_t r;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                $display("txn %0d: valid=%0b ill=%0b ctrl=%03b d1=%h d2=%h s2=%h rd=%0d ctl=%04b lu=%0b",
                         n_txn, valid_o, illegal_o, alu_ctrl_o, data1_o, data2_o, rs2_data_o,
                         rd_addr_o, {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}, load_use_o);
                chk("valid_o",    32'(valid_o),    32'(r.valid));
                chk("illegal_o",  32'(illegal_o),  32'(r.illegal));
                chk("ALUCtrl_o",  32'(alu_ctrl_o), 32'(r.ctrl));
                chk("data1_o",    data1_o,         r.d1);
                chk("data2_o",    data2_o,         r.d2);
                chk("rs2_data_o", rs2_data_o,      r.rs2d);
                chk("rs1_addr_o", 32'(rs1_addr_o), 32'(r.rs1a));
                chk("rs2_addr_o", 32'(rs2_addr_o), 32'(r.rs2a));
                chk("rd_addr_o",  32'(rd_addr_o),  32'(r.rd));
                chk("ctl_bits",   32'({reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o}), 32'(r.ctl));
                chk("load_use_o", 32'(load_use_o), 32'(r.lu));
                n_txn++;
            end
        end
    end

    initial begin
        vec_t v, addv;
        exp_t z, e5, addexp;
        z = '0;
        v = vrand_rst();
        step(v, z, 1'b0);       // first edge: registers unknown before it, record flushed below
        void'(sb.pop_front());
        pending = z;

        // reset with random inputs
        step(vrand_rst(), z, 1'b0);
        step(vrand_rst(), z, 1'b0);
        // SUB
        step(vi(1, 2'b10, 0, 10'b0100000_000, 32'd9, 32'd4, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1000),
             ex(1, 0, 3'b100, 32'd9, 32'd4, 32'd4, 5'd1, 5'd2, 5'd3, 4'b1000), 1'b0);
        // SRAI: B is imm[4:0] only
        step(vi(1, 2'b11, 1, 10'b0100000_101, 32'h80, 32'h77, 32'h405, 5'd6, 5'd5, 5'd7, 4'b1000),
             ex(1, 0, 3'b111, 32'h80, 32'd5, 32'h77, 5'd6, 5'd5, 5'd7, 4'b1000), 1'b0);
        // illegal I-type f3=011: ADD, reg_write and mem_write suppressed
        step(vi(1, 2'b11, 1, 10'b0000000_011, 32'd1, 32'd2, 32'h10, 5'd1, 5'd2, 5'd8, 4'b1010),
             ex(1, 1, 3'b011, 32'd1, 32'h10, 32'd2, 5'd1, 5'd2, 5'd8, 4'b0000), 1'b0);
        // load into x5
        e5 = ex(1, 0, 3'b011, 32'h100, 32'd8, 32'h33, 5'd2, 5'd0, 5'd5, 4'b1101);
        step(vi(1, 2'b00, 1, 10'b0, 32'h100, 32'h33, 32'd8, 5'd2, 5'd0, 5'd5, 4'b1101), e5, 1'b0);
        // dependent ADD reads x5 -> hazard; stall three cycles, contents frozen
        addv   = vi(1, 2'b10, 0, 10'b0, 32'h10, 32'h20, 32'h0, 5'd5, 5'd9, 5'd10, 4'b1000);
        addexp = ex(1, 0, 3'b011, 32'h10, 32'h20, 32'h20, 5'd5, 5'd9, 5'd10, 4'b1000);
        v = addv; v.stall = 1'b1;
        step(v, e5, 1'b1);
        step(v, e5, 1'b1);
        step(v, e5, 1'b1);
        // flush while stalled -> bubble
        v.flush = 1'b1;
        step(v, z, 1'b1);
        step(addv, addexp, 1'b0);
        // load into x0 followed by a reader of x0: no hazard
        step(vi(1, 2'b00, 1, 10'b0, 32'h200, 32'h0, 32'd4, 5'd5, 5'd0, 5'd0, 4'b1101),
             ex(1, 0, 3'b011, 32'h200, 32'd4, 32'h0, 5'd5, 5'd0, 5'd0, 4'b1101), 1'b0);
        // MUL, reading x0
        step(vi(1, 2'b10, 0, 10'b0000001_000, 32'd3, 32'd7, 32'h0, 5'd0, 5'd0, 5'd11, 4'b1000),
             ex(1, 0, 3'b101, 32'd3, 32'd7, 32'd7, 5'd0, 5'd0, 5'd11, 4'b1000), 1'b0);
        // load into x12, then store using x12 as rs2 -> hazard on rs2
        step(vi(1, 2'b00, 1, 10'b0, 32'h40, 32'h1, 32'h0, 5'd1, 5'd2, 5'd12, 4'b1101),
             ex(1, 0, 3'b011, 32'h40, 32'h0, 32'h1, 5'd1, 5'd2, 5'd12, 4'b1101), 1'b0);
        step(vi(1, 2'b00, 1, 10'b0, 32'h500, 32'h66, 32'h14, 5'd3, 5'd12, 5'd0, 4'b0010),
             ex(1, 0, 3'b011, 32'h500, 32'h14, 32'h66, 5'd3, 5'd12, 5'd0, 4'b0010), 1'b1);
        // branch -> SUB on register operands
        step(vi(1, 2'b01, 0, 10'b0, 32'd5, 32'd5, 32'h99, 5'd4, 5'd6, 5'd0, 4'b0000),
             ex(1, 0, 3'b100, 32'd5, 32'd5, 32'd5, 5'd4, 5'd6, 5'd0, 4'b0000), 1'b0);
        // valid_i=0 -> bubble despite live control inputs
        step(vi(0, 2'b10, 0, 10'b0, 32'hDEAD, 32'hBEEF, 32'h1, 5'd1, 5'd2, 5'd3, 4'b1111), z, 1'b0);
        // XOR
        step(vi(1, 2'b10, 0, 10'b0000000_100, 32'hF0, 32'h0F, 32'h0, 5'd7, 5'd8, 5'd9, 4'b1000),
             ex(1, 0, 3'b001, 32'hF0, 32'h0F, 32'h0F, 5'd7, 5'd8, 5'd9, 4'b1000), 1'b0);
        // ADDI with non-zero funct7 (immediate bits) and all-ones immediate
        step(vi(1, 2'b11, 1, 10'b0000011_000, 32'h10, 32'hAB, 32'hFFFFFFFF, 5'd1, 5'd3, 5'd4, 4'b1000),
             ex(1, 0, 3'b110, 32'h10, 32'hFFFFFFFF, 32'hAB, 5'd1, 5'd3, 5'd4, 4'b1000), 1'b0);
        // illegal R-type
        step(vi(1, 2'b10, 0, 10'b0100000_111, 32'd1, 32'd2, 32'h0, 5'd1, 5'd2, 5'd5, 4'b1010),
             ex(1, 1, 3'b011, 32'd1, 32'd2, 32'd2, 5'd1, 5'd2, 5'd5, 4'b0000), 1'b0);
        // AND, SLL
        step(vi(1, 2'b10, 0, 10'b0000000_111, 32'hC, 32'hA, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1000),
             ex(1, 0, 3'b000, 32'hC, 32'hA, 32'hA, 5'd1, 5'd2, 5'd3, 4'b1000), 1'b0);
        step(vi(1, 2'b10, 0, 10'b0000000_001, 32'd1, 32'd4, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1000),
             ex(1, 0, 3'b010, 32'd1, 32'd4, 32'd4, 5'd1, 5'd2, 5'd3, 4'b1000), 1'b0);
        // flush alone
        v = addv; v.flush = 1'b1;
        step(v, z, 1'b0);
        // mid-run reset, then idle
        step(vrand_rst(), z, 1'b0);
        step(vi(0, 2'b00, 0, 10'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'b0000), z, 1'b0);
`ifdef ID_EX_FWD_EN
        // Expectations below are what is seen while the NEXT vector's forwarding inputs apply.
        // ADD x3,x3: both EX/MEM(0xAA) and MEM/WB(0xBB) match -> 0xAA
        step(vi(1, 2'b10, 0, 10'b0, 32'h11, 32'h22, 32'h0, 5'd3, 5'd3, 5'd1, 4'b1000),
             ex(1, 0, 3'b011, 32'hAA, 32'hAA, 32'hAA, 5'd3, 5'd3, 5'd1, 4'b1000), 1'b0);
        v = vi(0, 2'b00, 0, 10'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'b0000);
        v.stall = 1'b1;
        v.ex_rd = 5'd3; v.ex_wr = 1'b1; v.ex_data = 32'hAA;
        v.wb_rd = 5'd3; v.wb_wr = 1'b1; v.wb_data = 32'hBB;
        // held; next vector drops EX/MEM write -> 0xBB
        step(v, ex(1, 0, 3'b011, 32'hBB, 32'hBB, 32'hBB, 5'd3, 5'd3, 5'd1, 4'b1000), 1'b0);
        v.ex_wr = 1'b0;
        // held; next vector forwards nothing -> registered values
        step(v, ex(1, 0, 3'b011, 32'h11, 32'h22, 32'h22, 5'd3, 5'd3, 5'd1, 4'b1000), 1'b0);
        v = vi(0, 2'b00, 0, 10'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'b0000);
        step(v, z, 1'b0);
        // ADDI: B is the immediate and is not forwarded; store data still is
        step(vi(1, 2'b11, 1, 10'b0, 32'h11, 32'h22, 32'd7, 5'd3, 5'd3, 5'd1, 4'b1000),
             ex(1, 0, 3'b110, 32'hAA, 32'd7, 32'hAA, 5'd3, 5'd3, 5'd1, 4'b1000), 1'b0);
        v.ex_rd = 5'd3; v.ex_wr = 1'b1; v.ex_data = 32'hAA;
        step(v, z, 1'b0);
        // x0 never forwards
        step(vi(1, 2'b10, 0, 10'b0, 32'd5, 32'd6, 32'h0, 5'd0, 5'd0, 5'd2, 4'b1000),
             ex(1, 0, 3'b011, 32'd5, 32'd6, 32'd6, 5'd0, 5'd0, 5'd2, 4'b1000), 1'b0);
        v.ex_rd = 5'd0;
        step(v, z, 1'b0);
`endif
        step(vi(0, 2'b00, 0, 10'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 4'b0000), z, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
